// File: rtl/data_memory_mp_if.sv
// Bus bundle for the multi-read-port data memory: one store port plus NUM_RD
// independent read ports, each with its own valid and error pulse.
interface data_memory_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NUM_RD = 2
);
    logic                     busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_err;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD-1:0]        rd_err;
    logic                     err_seen;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, wr_err, rd_data, rd_valid, rd_err, err_seen
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output busy, wr_err, rd_data, rd_valid, rd_err, err_seen
    );
endinterface

// File: rtl/data_memory_mp.sv
// Multi-read, single-write data memory with 1-cycle reads, write-to-read forwarding,
// out-of-range detection and a post-reset clear sequencer.
module data_memory_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 70,
    parameter int NUM_RD = 2
) (
    input  logic             clk,
    input  logic             reset,
    data_memory_mp_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]  DEPTH_X  = DEPTH[ADDR_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                   r_state;
    logic [IDX_W-1:0]         r_clr_ptr;
    logic                     r_busy;
    logic                     r_wr_err;
    logic                     r_err_seen;
    logic [NUM_RD*DATA_W-1:0] r_rd_data_p1;
    logic [NUM_RD-1:0]        r_vld_p1;
    logic [NUM_RD-1:0]        r_rd_err_p1;

    logic [DATA_W-1:0]        r_mem [DEPTH];

    logic                     w_wr_in;
    logic                     w_mem_we;
    logic [IDX_W-1:0]         w_mem_idx;
    logic [DATA_W-1:0]        w_mem_wdata;
    logic [ADDR_W-1:0]        w_rd_addr [NUM_RD];
    logic [NUM_RD-1:0]        w_rd_in;
    logic [DATA_W-1:0]        w_rd_word [NUM_RD];

    assign w_wr_in = ({1'b0, bus.wr_addr} < DEPTH_X);

    // Single write port shared between the clear sequencer and normal stores.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = r_clr_ptr;
        w_mem_wdata = '0;
        if (reset) begin
            if (r_state == S_CLEAR) begin
                w_mem_we = 1'b1;
            end else if (bus.wr_en && w_wr_in) begin
                w_mem_we    = 1'b1;
                w_mem_idx   = bus.wr_addr[IDX_W-1:0];
                w_mem_wdata = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // A store on the same edge to the same in-range address wins over the array contents.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_addr[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
            w_rd_in[k]   = ({1'b0, w_rd_addr[k]} < DEPTH_X);
            w_rd_word[k] = r_mem[w_rd_addr[k][IDX_W-1:0]];
            if (bus.wr_en && w_wr_in && (bus.wr_addr == w_rd_addr[k])) begin
                w_rd_word[k] = bus.wr_data;
            end
        end
    end

    // Stage p0 -> p1: control FSM and registered read outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_CLEAR;
            r_clr_ptr    <= '0;
            r_busy       <= 1'b1;
            r_wr_err     <= 1'b0;
            r_err_seen   <= 1'b0;
            r_rd_data_p1 <= '0;
            r_vld_p1     <= '0;
            r_rd_err_p1  <= '0;
        end else begin
            r_wr_err    <= 1'b0;
            r_vld_p1    <= '0;
            r_rd_err_p1 <= '0;
            case (r_state)
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LAST_IDX) begin
                        r_state   <= S_READY;
                        r_busy    <= 1'b0;
                        r_clr_ptr <= '0;
                    end
                end
                S_READY: begin
                    if (bus.wr_en && !w_wr_in) begin
                        r_wr_err   <= 1'b1;
                        r_err_seen <= 1'b1;
                    end
                    for (int k = 0; k < NUM_RD; k++) begin
                        if (bus.rd_en[k]) begin
                            r_vld_p1[k] <= 1'b1;
                            if (w_rd_in[k]) begin
                                r_rd_data_p1[k*DATA_W +: DATA_W] <= w_rd_word[k];
                            end else begin
                                r_rd_data_p1[k*DATA_W +: DATA_W] <= '0;
                                r_rd_err_p1[k] <= 1'b1;
                                r_err_seen     <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.wr_err   = r_wr_err;
    assign bus.err_seen = r_err_seen;
    assign bus.rd_data  = r_rd_data_p1;
    assign bus.rd_valid = r_vld_p1;
    assign bus.rd_err   = r_rd_err_p1;
endmodule

// File: tb/tb_data_memory_mp.sv
// Scoreboard bench for data_memory_mp: reads push expected words into per-port
// queues; a negedge monitor pops and compares whenever rd_valid is seen.
module tb_data_memory_mp;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 70;
    localparam int NR    = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_memory_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    data_memory_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_RD(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic rd(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        bus.rd_en[k] = 1'b1;
        bus.rd_addr[k*AW +: AW] = a;
        if (k == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.rd_en = '0;
        bus.wr_en = 1'b0;
    endtask

    task automatic count_busy();
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.rd_valid[0]) begin
            if (q0.size() == 0) check("unexpected_valid_p0", 1, 0);
            else begin
                e = q0.pop_front();
                check("rd_data_p0", 32'(bus.rd_data[0 +: DW]), 32'(e.data));
                check("rd_err_p0", 32'(bus.rd_err[0]), 32'(e.err));
            end
        end
        if (bus.rd_valid[1]) begin
            if (q1.size() == 0) check("unexpected_valid_p1", 1, 0);
            else begin
                e = q1.pop_front();
                check("rd_data_p1", 32'(bus.rd_data[DW +: DW]), 32'(e.data));
                check("rd_err_p1", 32'(bus.rd_err[1]), 32'(e.err));
            end
        end
    end

    initial begin
        bus.rd_en   = '0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset for two cycles, then the clear sequence.
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 1);
        check("reset_rd_valid", 32'(bus.rd_valid), 0);
        check("reset_rd_data", 32'(bus.rd_data), 0);
        check("reset_wr_err", 32'(bus.wr_err), 0);
        check("reset_err_seen", 32'(bus.err_seen), 0);
        reset = 1'b1;
        count_busy();
        check("busy_cycles", 32'(cnt), 70);
        for (int a = 0; a < DEPTH; a += 2) begin
            rd(0, 16'(a), 16'h0000, 1'b0);
            rd(1, 16'(a + 1), 16'h0000, 1'b0);
            step();
        end
        step();

        // Write then dual-port read of the same word.
        wr(16'd5, 16'hBEEF);
        step();
        rd(0, 16'd5, 16'hBEEF, 1'b0);
        rd(1, 16'd5, 16'hBEEF, 1'b0);
        step();

        // Same-edge forwarding over an old value.
        wr(16'd9, 16'hBEEF);
        step();
        wr(16'd9, 16'h1234);
        rd(0, 16'd9, 16'h1234, 1'b0);
        rd(1, 16'd9, 16'h1234, 1'b0);
        step();
        rd(0, 16'd9, 16'h1234, 1'b0);
        step();

        // Out-of-range store and loads; no aliasing through low address bits.
        wr(16'd70, 16'hAAAA);
        step();
        check("wr_err_pulse", 32'(bus.wr_err), 1);
        check("err_seen_set", 32'(bus.err_seen), 1);
        wr(16'h0105, 16'h7777);
        step();
        check("wr_err_again", 32'(bus.wr_err), 1);
        step();
        check("wr_err_cleared", 32'(bus.wr_err), 0);
        check("err_seen_sticky", 32'(bus.err_seen), 1);
        rd(0, 16'd70, 16'h0000, 1'b1);
        rd(1, 16'h0105, 16'h0000, 1'b1);
        step();
        wr(16'd69, 16'h6969);
        step();
        rd(0, 16'd69, 16'h6969, 1'b0);
        rd(1, 16'hFFFF, 16'h0000, 1'b1);
        step();
        rd(0, 16'd5, 16'hBEEF, 1'b0);
        rd(1, 16'd6, 16'h0000, 1'b0);
        step();

        // Data holds when the port is idle.
        wr(16'd3, 16'h5555);
        step();
        rd(0, 16'd3, 16'h5555, 1'b0);
        step();
        step();
        check("idle_rd_valid", 32'(bus.rd_valid), 0);
        check("idle_rd_data_hold", 32'(bus.rd_data[0 +: DW]), 32'h5555);

        // Reset in the middle of the clear sequence; requests during busy are ignored.
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 30; i++) step();
        reset = 1'b0;
        wr(16'd5, 16'hDEAD);
        bus.rd_en = 2'b11;
        bus.rd_addr = {16'd100, 16'd5};
        @(posedge clk);
        #1;
        check("midclr_busy", 32'(bus.busy), 1);
        check("midclr_err_seen", 32'(bus.err_seen), 0);
        reset = 1'b1;
        count_busy();
        check("busy_cycles_restart", 32'(cnt), 70);
        bus.rd_en = '0;
        bus.wr_en = 1'b0;
        check("busy_no_err_seen", 32'(bus.err_seen), 0);
        check("busy_no_wr_err", 32'(bus.wr_err), 0);
        rd(0, 16'd5, 16'h0000, 1'b0);
        rd(1, 16'd9, 16'h0000, 1'b0);
        step();
        rd(0, 16'd69, 16'h0000, 1'b0);
        rd(1, 16'd3, 16'h0000, 1'b0);
        step();
        step();
        step();

        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
